// File: rtl/uart_cmd_sequencer_pkg.sv
// Shared types and constants for the UART command sequencer: FSM states,
// ASCII codes, line lengths and the register-address decode helper.
package uart_cmd_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_PROMPT,
        ST_RECV,
        ST_EXEC_WR,
        ST_EXEC_RD,
        ST_RESP,
        ST_ERR
    } state_t;

    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_SP     = 8'h20;
    localparam logic [7:0] ASCII_PROMPT = 8'h3E;
    localparam logic [7:0] ASCII_W      = 8'h57;
    localparam logic [7:0] ASCII_R      = 8'h52;
    localparam logic [7:0] ASCII_US     = 8'h5F;
    localparam logic [7:0] ASCII_QM     = 8'h3F;
    localparam logic [7:0] ASCII_ZERO   = 8'h30;
    localparam logic [7:0] ASCII_O      = 8'h4F;
    localparam logic [7:0] ASCII_K      = 8'h4B;

    localparam int WR_LINE_LEN = 15;
    localparam int RD_LINE_LEN = 6;
    localparam int LINE_MAX    = 15;
    localparam int RESP_BYTES  = 10;

    // Address is "0d" with d a decimal digit below num_regs.
    function automatic logic is_addr(input logic [7:0] hi, input logic [7:0] lo, input int num_regs);
        return (hi == ASCII_ZERO) && (lo >= ASCII_ZERO) &&
               ((int'(lo) - int'(ASCII_ZERO)) < num_regs);
    endfunction

endpackage

// File: rtl/uart_cmd_sequencer_tx_seq.sv
// Steps a loaded response vector (first byte in the MSBs) out over the
// tx_valid/tx_ready handshake, one byte per accepted transfer.
module uart_tx_seq
    import uart_cmd_sequencer_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    load_i,
    input  logic [RESP_BYTES*8-1:0] load_data_i,
    input  logic [3:0]              load_len_i,
    input  logic                    tx_ready_i,
    output logic [7:0]              tx_data_o,
    output logic                    tx_valid_o,
    output logic                    done_o
);

    logic [RESP_BYTES*8-1:0] shift_q;
    logic [3:0]              remain_q;
    logic [7:0]              data_q;
    logic                    valid_q;
    logic                    fire;

    assign fire       = valid_q && tx_ready_i;
    assign done_o     = fire && (remain_q == 4'd0);
    assign tx_data_o  = data_q;
    assign tx_valid_o = valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q  <= '0;
            remain_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else if (load_i && !valid_q) begin
            data_q   <= load_data_i[RESP_BYTES*8-1 -: 8];
            shift_q  <= load_data_i << 8;
            remain_q <= load_len_i - 4'd1;
            valid_q  <= 1'b1;
        end else if (fire) begin
            if (remain_q == 4'd0) begin
                valid_q <= 1'b0;
            end else begin
                data_q   <= shift_q[RESP_BYTES*8-1 -: 8];
                shift_q  <= shift_q << 8;
                remain_q <= remain_q - 4'd1;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// ASCII line-command front end to a 64-bit register file.
// Define UART_CMD_ECHO_EN to echo every byte accepted in RECV.
module uart_cmd_sequencer
    import uart_cmd_sequencer_pkg::*;
#(
    parameter int NUM_REGS   = 9,
    parameter int RD_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    output logic [3:0]  reg_addr,
    output logic [63:0] reg_wdata,
    input  logic [63:0] reg_rdata,
    input  logic        reg_rd_valid,
    output logic        busy,
    output logic        overrun
);

    localparam int TW = $clog2(RD_TIMEOUT + 1) + 1;

    state_t                  state_q;
    logic [7:0]              line_q [LINE_MAX];
    logic [3:0]              len_q;
    logic                    parse_q;
    logic                    tx_started_q;
    logic                    rd_resp_q;
    logic                    wr_en_q;
    logic                    rd_en_q;
    logic [3:0]              addr_q;
    logic [63:0]             wdata_q;
    logic [63:0]             rdata_q;
    logic [TW-1:0]           timer_q;

    logic                    echo_busy;
    logic                    rx_accept;
    logic                    tx_load;
    logic                    tx_done;
    logic [RESP_BYTES*8-1:0] tx_vec;
    logic [3:0]              tx_len;
    logic [7:0]              last_byte;
    logic                    line_is_wr;
    logic                    line_is_rd;

`ifdef UART_CMD_ECHO_EN
    assign echo_busy = tx_valid;
`else
    assign echo_busy = 1'b0;
`endif

    assign rx_accept  = rx_valid && (state_q == ST_RECV) && !parse_q && !echo_busy;
    assign overrun    = rx_valid && !rx_accept && !RST;
    assign busy       = (state_q != ST_RECV);
    assign reg_wr_en  = wr_en_q;
    assign reg_rd_en  = rd_en_q;
    assign reg_addr   = addr_q;
    assign reg_wdata  = wdata_q;
    assign last_byte  = (len_q == 4'd0) ? 8'd0 : line_q[len_q - 4'd1];

    assign line_is_wr = (len_q == 4'(WR_LINE_LEN)) && (line_q[0] == ASCII_W) &&
                        (line_q[1] == ASCII_US) && (line_q[4] == ASCII_SP) &&
                        is_addr(line_q[2], line_q[3], NUM_REGS);
    assign line_is_rd = (len_q == 4'(RD_LINE_LEN)) && (line_q[0] == ASCII_R) &&
                        (line_q[1] == ASCII_US) && is_addr(line_q[2], line_q[3], NUM_REGS);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tx_vec = '0;
        tx_len = 4'd1;
        case (state_q)
            ST_PROMPT: tx_vec = {ASCII_PROMPT, 72'd0};
            ST_ERR: begin
                tx_vec = {ASCII_QM, ASCII_CR, ASCII_LF, 56'd0};
                tx_len = 4'd3;
            end
            ST_RESP: begin
                if (rd_resp_q) begin
                    tx_vec = {rdata_q, ASCII_CR, ASCII_LF};
                    tx_len = 4'd10;
                end else begin
                    tx_vec = {ASCII_O, ASCII_K, ASCII_CR, ASCII_LF, 48'd0};
                    tx_len = 4'd4;
                end
            end
            ST_RECV: tx_vec = {rx_data, 72'd0};
            default: tx_vec = '0;
        endcase
        // Responses only start once any echo byte still in flight has drained.
        tx_load = ((state_q == ST_PROMPT) || (state_q == ST_RESP) || (state_q == ST_ERR)) &&
                  !tx_started_q && !tx_valid;
`ifdef UART_CMD_ECHO_EN
        if (rx_accept) tx_load = 1'b1;
`endif
    end

    // NOTE: the line buffer sits in the reset domain so a reset always abandons a partial line.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_PROMPT;
            for (int i = 0; i < LINE_MAX; i++) line_q[i] <= '0;
            len_q        <= '0;
            parse_q      <= 1'b0;
            tx_started_q <= 1'b0;
            rd_resp_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            timer_q      <= '0;
        end else begin
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            if (tx_load && (state_q != ST_RECV)) tx_started_q <= 1'b1;
            case (state_q)
                ST_PROMPT: if (tx_done && tx_started_q) begin
                    state_q      <= ST_RECV;
                    tx_started_q <= 1'b0;
                    len_q        <= '0;
                end
                ST_RECV: begin
                    if (parse_q) begin
                        parse_q <= 1'b0;
                        if (line_is_wr) begin
                            state_q <= ST_EXEC_WR;
                            wr_en_q <= 1'b1;
                            addr_q  <= line_q[3][3:0];
                            wdata_q <= {line_q[5], line_q[6], line_q[7], line_q[8],
                                        line_q[9], line_q[10], line_q[11], line_q[12]};
                        end else if (line_is_rd) begin
                            state_q <= ST_EXEC_RD;
                            rd_en_q <= 1'b1;
                            addr_q  <= line_q[3][3:0];
                            timer_q <= '0;
                        end else begin
                            state_q <= ST_ERR;
                            len_q   <= '0;
                        end
                    end else if (rx_accept) begin
                        if (len_q == 4'(LINE_MAX)) begin
                            state_q <= ST_ERR;
                            len_q   <= '0;
                        end else if (rx_data == ASCII_LF && last_byte != ASCII_CR) begin
                            state_q <= ST_ERR;
                            len_q   <= '0;
                        end else begin
                            line_q[len_q] <= rx_data;
                            len_q         <= len_q + 4'd1;
                            parse_q       <= (rx_data == ASCII_LF);
                        end
                    end
                end
                ST_EXEC_WR: begin
                    state_q   <= ST_RESP;
                    rd_resp_q <= 1'b0;
                end
                ST_EXEC_RD: begin
                    if (reg_rd_valid) begin
                        rdata_q   <= reg_rdata;
                        rd_resp_q <= 1'b1;
                        state_q   <= ST_RESP;
                    end else if (timer_q == TW'(RD_TIMEOUT)) begin
                        state_q <= ST_ERR;
                        len_q   <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_RESP, ST_ERR: if (tx_done && tx_started_q) begin
                    state_q      <= ST_PROMPT;
                    tx_started_q <= 1'b0;
                end
                default: state_q <= ST_PROMPT;
            endcase
        end
    end

    uart_tx_seq u_tx_seq (
        .clk_i       (CLK),
        .rst_i       (RST),
        .load_i      (tx_load),
        .load_data_i (tx_vec),
        .load_len_i  (tx_len),
        .tx_ready_i  (tx_ready),
        .tx_data_o   (tx_data),
        .tx_valid_o  (tx_valid),
        .done_o      (tx_done)
    );

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Scoreboard bench for uart_cmd_sequencer: a line-level reference model queues
// expected TX bytes and register strobes; a monitor pops and compares them.
module tb_uart_cmd_sequencer;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    localparam int NREGS = 9;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [3:0]  reg_addr;
    logic [63:0] reg_wdata;
    logic [63:0] reg_rdata = '0;
    logic        reg_rd_valid = 1'b0;
    logic        busy;
    logic        overrun;

    uart_cmd_sequencer #(.NUM_REGS(NREGS), .RD_TIMEOUT(255)) dut (
        .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_rd_valid(reg_rd_valid),
        .busy(busy), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    logic [7:0]  exp_tx[$];
    logic [67:0] exp_wr[$];
    logic [3:0]  exp_rd[$];
    logic [63:0] model_regs[NREGS];
    logic [7:0]  cur_line[$];

    bit          rd_noresp = 1'b0;
    int          rd_delay = 3;
    bit          rand_ready = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_msg(input string name, input string detail);
        checks++;
        failures++;
        $display("FAIL %s %s", name, detail);
    endtask

    // Monitor: compares every TX handshake and register strobe against the queues.
    always @(negedge CLK) begin
        if (RST) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("tx_hold_valid", 64'(tx_valid), 64'd1);
                check("tx_hold_data", 64'(tx_data), 64'(prev_data));
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) fail_msg("tx_extra", $sformatf("actual=%h required=none", tx_data));
                else check("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
            end
            if (reg_wr_en && reg_rd_en) fail_msg("strobe_overlap", "actual=both required=at_most_one");
            if (reg_wr_en) begin
                if (exp_wr.size() == 0) fail_msg("wr_extra", $sformatf("actual=addr %0d required=none", reg_addr));
                else begin
                    logic [67:0] e;
                    e = exp_wr.pop_front();
                    check("wr_addr", 64'(reg_addr), 64'(e[67:64]));
                    check("wr_data", reg_wdata, e[63:0]);
                end
            end
            if (reg_rd_en) begin
                if (exp_rd.size() == 0) fail_msg("rd_extra", $sformatf("actual=addr %0d required=none", reg_addr));
                else check("rd_addr", 64'(reg_addr), 64'(exp_rd.pop_front()));
            end
        end
    end

    // Register-file responder: returns the model contents rd_delay cycles after reg_rd_en.
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (reg_rd_en && !RST && !rd_noresp) begin
                int a;
                a = int'(reg_addr);
                repeat (rd_delay) @(posedge CLK);
                #1;
                reg_rdata    = (a < NREGS) ? model_regs[a] : 64'hDEAD_BEEF_DEAD_BEEF;
                reg_rd_valid = 1'b1;
                @(posedge CLK);
                #1;
                reg_rd_valid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic add_str(input string s);
        for (int i = 0; i < s.len(); i++) cur_line.push_back(s[i]);
    endtask

    task automatic push_resp(input string s);
        for (int i = 0; i < s.len(); i++) exp_tx.push_back(s[i]);
    endtask

    // Reference model: applies the line rules to cur_line, queues expectations,
    // and returns how many bytes the DUT will consume before reacting.
    task automatic model_line(input bit noresp, output int consumed);
        logic [7:0] acc[$];
        bit done = 1'b0;
        bit err = 1'b0;
        consumed = 0;
        foreach (cur_line[i]) begin
            if (!done) begin
                consumed++;
                if (acc.size() == 15) begin
                    err = 1'b1; done = 1'b1;
                end else if (cur_line[i] == LF) begin
                    if (acc.size() > 0 && acc[acc.size()-1] == CR) acc.push_back(LF);
                    else err = 1'b1;
                    done = 1'b1;
                end else begin
                    acc.push_back(cur_line[i]);
                end
            end
        end
        if (!err) begin
            bit addr_ok;
            int a;
            addr_ok = (acc.size() >= 4) && acc[2] == "0" && acc[3] >= "0" && (int'(acc[3]) - 48) < NREGS;
            a = addr_ok ? int'(acc[3]) - 48 : 0;
            if (acc.size() == 15 && acc[0] == "W" && acc[1] == "_" && acc[4] == " " && addr_ok) begin
                logic [63:0] d = '0;
                for (int k = 5; k <= 12; k++) d = {d[55:0], acc[k]};
                model_regs[a] = d;
                exp_wr.push_back({4'(a), d});
                push_resp("OK\r\n>");
            end else if (acc.size() == 6 && acc[0] == "R" && acc[1] == "_" && addr_ok) begin
                exp_rd.push_back(4'(a));
                if (noresp) push_resp("?\r\n>");
                else begin
                    for (int k = 7; k >= 0; k--) exp_tx.push_back(model_regs[a][k*8 +: 8]);
                    push_resp("\r\n>");
                end
            end else begin
                err = 1'b1;
            end
        end
        if (err) push_resp("?\r\n>");
    endtask

    // Called at posedge+1; leaves the bench at posedge+1.
    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            rx_data  = cur_line[i];
            rx_valid = 1'b1;
            @(posedge CLK); #1;
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(exp_tx.size() == 0 && !busy) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 3000) fail_msg(name, $sformatf("actual=timeout pending=%0d required=idle", exp_tx.size()));
        @(posedge CLK); #1;
    endtask

    task automatic apply_line(input string name, input bit noresp);
        int n;
        rd_noresp = noresp;
        model_line(noresp, n);
        send_bytes(n);
        wait_idle(name);
        rd_noresp = 1'b0;
    endtask

    task automatic wait_tx_valid(input string name);
        int n = 0;
        while (!tx_valid && n < 500) begin @(posedge CLK); #1; n++; end
        if (!tx_valid) fail_msg(name, "actual=tx_valid_low required=tx_valid_high");
    endtask

    task automatic add_data_bytes();
        for (int k = 0; k < 8; k++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            if (b == LF) b = 8'h0B;
            cur_line.push_back(b);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < NREGS; i++) model_regs[i] = {$urandom, $urandom};
        model_regs[8] = 64'hA5A5_A5A5_A5A5_A5A5;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_wr_en", 64'(reg_wr_en), 64'd0);
        check("rst_rd_en", 64'(reg_rd_en), 64'd0);
        check("rst_addr", 64'(reg_addr), 64'd0);
        check("rst_wdata", reg_wdata, 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        @(posedge CLK); #1;
        exp_tx.push_back(8'h3E);
        RST = 1'b0;
        wait_idle("prompt_after_reset");
        check("busy_after_prompt", 64'(busy), 64'd0);

        // Directed write and read
        cur_line.delete(); add_str("W_03 ");
        for (int k = 1; k <= 8; k++) cur_line.push_back(8'(k));
        add_str("\r\n");
        apply_line("wr_03", 1'b0);
        rd_delay = 3;
        cur_line.delete(); add_str("R_08\r\n"); apply_line("rd_08", 1'b0);
        cur_line.delete(); add_str("R_03\r\n"); apply_line("rd_03", 1'b0);

        // Rejected lines
        cur_line.delete(); add_str("R_09\r\n"); apply_line("rd_09", 1'b0);
        cur_line.delete(); add_str("X_00\r\n"); apply_line("bad_cmd", 1'b0);
        cur_line.delete(); add_str("R_01\n");   apply_line("lf_no_cr", 1'b0);
        cur_line.delete(); add_str("ABCDEFGHIJKLMNOP"); apply_line("overflow", 1'b0);
        cur_line.delete(); add_str("R_00\r\n"); apply_line("rd_timeout", 1'b1);

        // TX stall during RESP with an injected rx byte
        tx_ready = 1'b0;
        cur_line.delete(); add_str("W_05 "); add_data_bytes(); add_str("\r\n");
        model_line(1'b0, n);
        send_bytes(n);
        wait_tx_valid("stall_wait");
        repeat (5) begin @(posedge CLK); #1; end
        rx_data = 8'h41; rx_valid = 1'b1;
        #1;
        check("overrun_pulse", 64'(overrun), 64'd1);
        @(posedge CLK); #1;
        rx_valid = 1'b0;
        #1;
        check("overrun_clear", 64'(overrun), 64'd0);
        repeat (14) begin @(posedge CLK); #1; end
        tx_ready = 1'b1;
        wait_idle("stall_resume");

        // Reset in the middle of RESP
        tx_ready = 1'b0;
        cur_line.delete(); add_str("W_07 "); add_data_bytes(); add_str("\r\n");
        model_line(1'b0, n);
        send_bytes(n);
        wait_tx_valid("rst_mid_wait");
        RST = 1'b1;
        #1;
        check("rst_mid_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd1);
        exp_tx.delete();
        repeat (3) begin @(posedge CLK); #1; end
        check("rst_mid_wr_en", 64'(reg_wr_en), 64'd0);
        tx_ready = 1'b1;
        exp_tx.push_back(8'h3E);
        RST = 1'b0;
        wait_idle("prompt_after_rst_mid");

        // Randomized lines with random tx_ready backpressure
        rand_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            int d;
            cur_line.delete();
            rd_delay = $urandom_range(0, 5);
            d = $urandom_range(0, 8);
            case ($urandom_range(0, 6))
                0: begin add_str($sformatf("W_0%0d ", d)); add_data_bytes(); add_str("\r\n"); end
                1: add_str($sformatf("R_0%0d\r\n", d));
                2: add_str(($urandom_range(0, 1) == 0) ? "R_09\r\n" : $sformatf("R_1%0d\r\n", d));
                3: begin
                    cur_line.push_back(($urandom_range(0, 1) == 0) ? 8'h58 : 8'h72);
                    add_str($sformatf("_0%0d\r\n", d));
                end
                4: add_str($sformatf("R_0%0d\n", d));
                5: for (int k = 0; k < 16; k++) cur_line.push_back(8'($urandom_range(65, 90)));
                default: begin add_str($sformatf("W_0%0d-", d)); add_data_bytes(); add_str("\r\n"); end
            endcase
            apply_line("random_line", 1'b0);
        end
        rand_ready = 1'b0;
        tx_ready = 1'b1;

        check("tx_queue_drained", 64'(exp_tx.size()), 64'd0);
        check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
        check("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_sequencer.md
UART_CMD_SEQUENCER -- requirements
Module: uart_cmd_sequencer

Interface
REQ-001 SHALL have parameter NUM_REGS, default 9, meaning number of addressable 64-bit registers (valid ASCII addresses "00".."08").
REQ-002 SHALL have parameter RD_TIMEOUT, default 255, meaning max cycles to wait for reg_rd_valid.
REQ-003 SHALL have port CLK  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports rx_data  in  8  and rx_valid  in  1: received UART byte, 1-cycle strobe, no backpressure.
REQ-006 SHALL have ports tx_data  out  8, tx_valid  out  1 and tx_ready  in  1: transmit byte handshake.
REQ-007 SHALL have ports reg_wr_en  out  1, reg_rd_en  out  1, reg_addr  out  4 and reg_wdata  out  64: register-file access.
REQ-008 SHALL have ports reg_rdata  in  64 and reg_rd_valid  in  1: read return.
REQ-009 SHALL have ports busy  out  1 (state != RECV) and overrun  out  1 (1-cycle pulse when an rx byte is dropped).

Function
REQ-010 SHALL implement states PROMPT, RECV, EXEC_WR, EXEC_RD, RESP and ERR.
REQ-011 Line format: write = "W_" + 2 addr chars + 0x20 + 8 raw data bytes + CR LF (15 bytes); read = "R_" + 2 addr chars + CR LF (6 bytes).
REQ-012 RECV: append each rx byte to a 15-byte line buffer; on LF preceded by CR, go to parse; LF without a preceding CR, or a 16th byte, goes to ERR.
REQ-013 Parse completes in the cycle after LF; "W_" with length 15, space at byte 4 and valid addr goes to EXEC_WR; "R_" with length 6 and valid addr goes to EXEC_RD; anything else goes to ERR.
REQ-014 Valid addr = two ASCII digits "0d" with d < NUM_REGS; reg_addr = d.
REQ-015 EXEC_WR: reg_wr_en high exactly 1 cycle, reg_wdata = data bytes with the first byte in [63:56]; then RESP sends "OK", CR, LF, '>'.
REQ-016 EXEC_RD: reg_rd_en high 1 cycle; wait for reg_rd_valid, capture reg_rdata; RESP sends 8 bytes MSB-first, CR, LF, '>'.
REQ-017 No reg_rd_valid within RD_TIMEOUT cycles after reg_rd_en SHALL go to ERR.
REQ-018 ERR sends '?', CR, LF, '>' and then returns to RECV with the buffer cleared.
REQ-019 TX: tx_data/tx_valid held stable until tx_ready; a byte is consumed on tx_valid&&tx_ready; next byte is presented no earlier than the following cycle.
REQ-020 rx bytes arriving outside RECV SHALL be dropped with an overrun pulse in the same cycle.
REQ-021 reg_wr_en and reg_rd_en SHALL never be high in the same cycle.

Reset
REQ-022 On RST: state=PROMPT, buffer/length=0, tx_valid=0, tx_data=0, reg_wr_en=0, reg_rd_en=0, reg_addr=0, reg_wdata=0, overrun=0, busy=1.
REQ-023 After RST release, PROMPT SHALL send '>' (0x3E) once, then enter RECV.
REQ-024 RST mid-transaction SHALL abandon the line and any pending TX byte immediately; no register strobe after assertion.

Configuration
REQ-025 With UART_CMD_ECHO_EN defined, each byte accepted in RECV SHALL be echoed on TX before the next accepted byte; bytes arriving during an echo are dropped (overrun).
REQ-026 Without UART_CMD_ECHO_EN, no echo is sent and RECV never drives tx_valid.

Structure
REQ-027 A shared package SHALL hold the state enum, ASCII constants (CR 0x0D, LF 0x0A, SP 0x20, PROMPT 0x3E, 'W', 'R', '_', '?') and line-length constants (15, 6).
REQ-028 The TX byte sequencer SHALL be a sub-module, uart_tx_seq (loads a 10-byte response vector plus length and steps it out over the handshake).

Verification
REQ-029 Reset release with tx_ready=1 -> single 0x3E on TX, then busy=0.
REQ-030 "W_03 " + 0x0102030405060708 + CR LF -> one reg_wr_en, reg_addr=3, reg_wdata=64'h0102030405060708; TX "OK\r\n>".
REQ-031 "R_08\r\n", reg_rdata=64'hA5A5..A5 returned 3 cycles later -> TX 8x 0xA5, 0x0D, 0x0A, 0x3E.
REQ-032 "R_09\r\n" and "X_00\r\n" -> no register strobe; TX "?\r\n>".
REQ-033 "R_00\r\n" with reg_rd_valid never asserted -> ERR after 255 cycles; 16-byte line without LF -> ERR.
REQ-034 tx_ready held 0 for 20 cycles during RESP -> tx_data stable; rx byte injected -> overrun pulse; RST asserted mid-RESP -> tx_valid=0 immediately.
